// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction fetch stage: FSM encoding,
// architectural instruction values and a saturating counter helper.
package fetch_unit_pkg;

    // FSM state encoding (kept as plain constants for legacy tools)
    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    // Opcode field [15:11] that identifies a HALT instruction
    localparam logic [4:0]  OPC_HALT  = 5'b00000;
    // Value presented on the IF/ID instruction register after reset
    localparam logic [15:0] NOP_INSTR = 16'h0800;
    // First fetch address after reset
    localparam logic [15:0] RESET_PC  = 16'h0000;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/fetch_unit_reg_16b.sv
// Generic 16-bit register with write enable and synchronous reset value.
module reg_16b #(
    parameter logic [15:0] RST_VAL = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_we,
    input  logic [15:0] i_d,
    output logic [15:0] o_q
);

    logic [15:0] r_q;

    // Reset has priority over a write in the same cycle
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (rst) begin
            r_q <= RST_VAL;
        end else if (i_we) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the PC into instruction memory, registers
// returned words into the IF/ID outputs, absorbs one word in a skid buffer
// while the pipeline is stalled, and stops fetching after a HALT.
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_rd,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_data,
    output logic        if_valid,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc_plus2,
    output logic        halted,
    output logic [15:0] fetch_cnt
);

    logic [1:0]  r_state;
    logic        r_if_valid;
    logic [15:0] r_fetch_cnt;
    logic        r_skid_valid;
    logic [15:0] r_skid_word;
    logic [15:0] r_skid_pc2;

    logic [15:0] w_pc;
    logic [15:0] w_pc_plus2;
    logic        w_redirect;
    logic        w_deliver_run;
    logic        w_deliver_hold;
    logic        w_deliver;
    logic        w_capture;
    logic [15:0] w_del_word;
    logic [15:0] w_del_pc2;
    logic        w_del_halt;
    logic        w_pc_we;
    logic [15:0] w_pc_d;

    // HALT state ignores redirect; rst is handled separately with top priority
    assign w_redirect     = redirect && (r_state != ST_HALT);
    assign w_pc_plus2     = w_pc + 16'd2;
    assign w_deliver_run  = (r_state == ST_RUN) && imem_ready && !stall && !w_redirect;
    assign w_capture      = (r_state == ST_RUN) && imem_ready &&  stall && !w_redirect;
    assign w_deliver_hold = (r_state == ST_HOLD) && !stall && !w_redirect;
    assign w_deliver      = w_deliver_run || w_deliver_hold;
    assign w_del_word     = w_deliver_hold ? r_skid_word : imem_data;
    assign w_del_pc2      = w_deliver_hold ? r_skid_pc2  : w_pc_plus2;
    assign w_del_halt     = (w_del_word[15:11] == OPC_HALT);

    // Next PC: redirect target, rewind onto a delivered HALT, or sequential advance
    always_comb begin
        // NOTE: defaults first so no path through this block infers a latch.
        w_pc_we = 1'b0;
        w_pc_d  = w_pc;
        if (w_redirect) begin
            w_pc_we = 1'b1;
            w_pc_d  = redirect_pc;
        end else if (w_deliver && w_del_halt) begin
            w_pc_we = 1'b1;
            w_pc_d  = w_del_pc2 - 16'd2;
        end else if (w_deliver_run || w_capture) begin
            w_pc_we = 1'b1;
            w_pc_d  = w_pc_plus2;
        end
    end

    reg_16b #(.RST_VAL(RESET_PC)) u_pc_reg (
        .clk  (clk),
        .rst  (rst),
        .i_we (w_pc_we),
        .i_d  (w_pc_d),
        .o_q  (w_pc)
    );

    reg_16b #(.RST_VAL(NOP_INSTR)) u_instr_reg (
        .clk  (clk),
        .rst  (rst),
        .i_we (w_deliver),
        .i_d  (w_del_word),
        .o_q  (if_instr)
    );

    reg_16b #(.RST_VAL(16'h0000)) u_pc2_reg (
        .clk  (clk),
        .rst  (rst),
        .i_we (w_deliver),
        .i_d  (w_del_pc2),
        .o_q  (if_pc_plus2)
    );

    // Control state: FSM, IF/ID valid, skid occupancy and delivery counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_RUN;
            r_if_valid   <= 1'b0;
            r_fetch_cnt  <= 16'h0000;
            r_skid_valid <= 1'b0;
        end else if (w_redirect) begin
            r_state      <= ST_RUN;
            r_if_valid   <= 1'b0;
            r_skid_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_capture) begin
                        r_skid_valid <= 1'b1;
                        r_state      <= ST_HOLD;
                    end else if (!stall) begin
                        r_if_valid <= imem_ready;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        r_skid_valid <= 1'b0;
                        r_if_valid   <= 1'b1;
                    end
                end
                default: ;
            endcase
            if (w_deliver) begin
                r_fetch_cnt <= sat_inc16(r_fetch_cnt);
                if (w_del_halt) begin
                    r_state <= ST_HALT;
                end else if (r_state == ST_HOLD) begin
                    r_state <= ST_RUN;
                end
            end
        end
    end

    // Skid payload: captured when a word arrives during a stall
    always_ff @(posedge clk) begin
        // NOTE: payload is not reset; r_skid_valid alone qualifies it.
        if (w_capture) begin
            r_skid_word <= imem_data;
            r_skid_pc2  <= w_pc_plus2;
        end
    end

    assign imem_rd   = (r_state == ST_RUN) && !rst;
    assign imem_addr = w_pc;
    assign if_valid  = r_if_valid;
    assign halted    = (r_state == ST_HALT);
    assign fetch_cnt = r_fetch_cnt;

endmodule
